// File: rtl/sha256_pkg.sv
// Shared constants and FSM encoding for the SHA-256 message padder.
package sha256_pkg;

  localparam int         BLK_BYTES  = 64;
  localparam int         LEN_OFFSET = 56;
  localparam logic [7:0] PAD_BYTE   = 8'h80;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    OUT       = 2'd1,
    OUT_EXTRA = 2'd2
  } state_t;

endpackage

// File: rtl/sha256_msg_padder.sv
// Streams message bytes into 512-bit SHA-256 blocks, appending the 0x80 marker,
// zero fill and the 64-bit big-endian bit length (spilling into an extra block when needed).
module sha256_msg_padder
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [0:511] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  state_t        state, state_nxt;
  logic [5:0]    byte_cnt;
  logic [63:0]   len_cnt, len_nxt;
  logic          pend_80, pend_len, first_q, last_q;
  logic [0:511]  blk_q, fill_blk, extra_blk;
  logic          accept, blk_hs, short_pad;

  assign accept    = in_valid && in_ready;
  assign blk_hs    = blk_valid && blk_ready;
  assign len_nxt   = len_cnt + 64'd8;
  assign short_pad = int'(byte_cnt) < (LEN_OFFSET - 1);

  // Block image after accepting the current byte; a last byte also lays down the padding.
  always_comb begin
    fill_blk = blk_q;
    for (int i = 0; i < BLK_BYTES; i++) begin
      if (i == int'(byte_cnt)) begin
        fill_blk[8*i +: 8] = in_data;
      end else if (in_last && (i > int'(byte_cnt))) begin
        if (i == int'(byte_cnt) + 1)
          fill_blk[8*i +: 8] = PAD_BYTE;
        else if (short_pad && (i >= LEN_OFFSET))
          fill_blk[8*i +: 8] = len_nxt[8*(BLK_BYTES-1-i) +: 8];
        else
          fill_blk[8*i +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    extra_blk = '0;
    extra_blk[0:7] = pend_80 ? PAD_BYTE : 8'h00;
    extra_blk[8*LEN_OFFSET +: 64] = len_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:      if (accept && (in_last || (&byte_cnt))) state_nxt = OUT;
      OUT:       if (blk_hs) state_nxt = pend_len ? OUT_EXTRA : FILL;
      OUT_EXTRA: if (blk_hs) state_nxt = FILL;
      default:   state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL);
    blk_valid = (state != FILL);
    blk_data  = blk_q;
    blk_first = first_q;
    blk_last  = last_q;
  end

  // Datapath: the first flag re-arms whenever a final block is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      len_cnt  <= '0;
      pend_80  <= 1'b0;
      pend_len <= 1'b0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
      blk_q    <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            blk_q    <= fill_blk;
            byte_cnt <= byte_cnt + 6'd1;
            len_cnt  <= len_nxt;
            if (in_last) begin
              last_q   <= short_pad;
              pend_len <= !short_pad;
              pend_80  <= &byte_cnt;
            end else begin
              last_q <= 1'b0;
            end
          end
        end
        OUT: begin
          if (blk_hs) begin
            first_q  <= last_q;
            byte_cnt <= '0;
            if (pend_len) begin
              blk_q  <= extra_blk;
              last_q <= 1'b1;
            end else if (last_q) begin
              len_cnt <= '0;
            end
          end
        end
        OUT_EXTRA: begin
          if (blk_hs) begin
            pend_80  <= 1'b0;
            pend_len <= 1'b0;
            first_q  <= 1'b1;
            len_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench: directed vector table, stall/reset sequences and random messages
// compared against a queue-based SHA-256 padding model.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [0:511] blk_data;
  logic         blk_first;
  logic         blk_last;

  sha256_msg_padder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:511] data;
    logic         first;
    logic         last;
  } exp_t;

  typedef struct {
    int          len;
    int          pat;
    int          exp_blocks;
    logic [63:0] exp_bits;
    int          ready_mode;
  } vector_t;

  exp_t         exp_q[$];
  logic [7:0]   msg_q[$];
  vector_t      vecs[9];
  int           total = 0;
  int           bad = 0;
  int           ready_mode = 0;
  int           blocks_seen = 0;
  logic [63:0]  last_len_seen = '0;
  logic [0:511] last_blk = '0;
  logic [0:511] abc_exp = {32'h61626380, 416'h0, 64'h18};

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pads the whole message the textbook way, then slices it into 64-byte blocks.
  task automatic model_push();
    logic [7:0]  pad[$];
    logic [63:0] bits;
    exp_t        e;
    int          nb;
    pad  = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    for (int k = 7; k >= 0; k--) pad.push_back(bits[8*k +: 8]);
    nb = pad.size() / 64;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 64; i++) e.data[8*i +: 8] = pad[64*b + i];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic build_msg(input int len, input int pat);
    msg_q.delete();
    for (int i = 0; i < len; i++) begin
      if (pat < 0)        msg_q.push_back(8'(8'h61 + i));
      else if (pat > 255) msg_q.push_back(8'($urandom_range(0, 255)));
      else                msg_q.push_back(8'(pat));
    end
  endtask

  task automatic applyStimulus(input bit with_last);
    int   idx = 0;
    int   guard = 0;
    logic acc;
    while ((idx < msg_q.size()) && (guard < 5000)) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = msg_q[idx];
      in_last  = in_valid ? (with_last && (idx == msg_q.size() - 1)) : 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (idx < msg_q.size()) checkOutput("send_timeout", 512'(0), 512'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (((exp_q.size() != 0) || !in_ready) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) checkOutput("drain_timeout", 512'(0), 512'(1));
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 512'(in_ready), 512'(1));
    checkOutput("rst_blk_valid", 512'(blk_valid), 512'(0));
    checkOutput("rst_blk_data", blk_data, 512'(0));
    checkOutput("rst_blk_first", 512'(blk_first), 512'(1));
    checkOutput("rst_blk_last", 512'(blk_last), 512'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    blk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       blk_ready = 1'b1;
        1:       blk_ready = 1'($urandom_range(0, 1));
        default: blk_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: every consumed block must match the next modelled block.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && blk_valid && blk_ready) begin
      blocks_seen++;
      last_len_seen = blk_data[448 +: 64];
      last_blk      = blk_data;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_block", 512'(1), 512'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("blk_data", blk_data, e.data);
        checkOutput("blk_first", 512'(blk_first), 512'(e.first));
        checkOutput("blk_last", 512'(blk_last), 512'(e.last));
      end
    end
  end

  initial begin
    vecs[0] = '{3,   -1,   1, 64'h18,  0};
    vecs[1] = '{55,  8'h61, 1, 64'h1B8, 0};
    vecs[2] = '{56,  8'h61, 2, 64'h1C0, 1};
    vecs[3] = '{64,  0,    2, 64'h200, 0};
    vecs[4] = '{3,   -1,   1, 64'h18,  1};
    vecs[5] = '{63,  8'hFF, 2, 64'h1F8, 1};
    vecs[6] = '{119, 8'h5A, 2, 64'h3B8, 0};
    vecs[7] = '{1,   8'hA5, 1, 64'h8,   1};
    vecs[8] = '{128, 300,  3, 64'h400, 1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();

    for (int v = 0; v < 9; v++) begin
      build_msg(vecs[v].len, vecs[v].pat);
      ready_mode  = vecs[v].ready_mode;
      blocks_seen = 0;
      model_push();
      applyStimulus(1'b1);
      drain();
      checkOutput("block_count", 512'(blocks_seen), 512'(vecs[v].exp_blocks));
      checkOutput("len_field", 512'(last_len_seen), 512'(vecs[v].exp_bits));
      if (vecs[v].pat < 0) checkOutput("abc_block", last_blk, abc_exp);
    end

    // Downstream stall: the presented block must hold until blk_ready rises.
    build_msg(3, -1);
    ready_mode = 2;
    model_push();
    applyStimulus(1'b1);
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall_valid", 512'(blk_valid), 512'(1));
      checkOutput("stall_data", blk_data, abc_exp);
      checkOutput("stall_first", 512'(blk_first), 512'(1));
      checkOutput("stall_last", 512'(blk_last), 512'(1));
      checkOutput("stall_in_ready", 512'(in_ready), 512'(0));
    end
    ready_mode = 0;
    @(negedge clk);
    checkOutput("stall_release_ready", 512'(blk_ready), 512'(1));
    @(negedge clk);
    checkOutput("stall_consumed", 512'(blk_valid), 512'(0));
    checkOutput("stall_queue_empty", 512'(exp_q.size()), 512'(0));
    @(posedge clk); #1;

    // Reset partway through a message, then a fresh "abc".
    build_msg(20, 8'h33);
    applyStimulus(1'b0);
    pulse_reset();
    build_msg(3, -1);
    blocks_seen = 0;
    model_push();
    applyStimulus(1'b1);
    drain();
    checkOutput("post_reset_count", 512'(blocks_seen), 512'(1));
    checkOutput("post_reset_abc", last_blk, abc_exp);

    // Reset while a full block is being presented.
    build_msg(64, 8'h44);
    ready_mode = 2;
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("mid_out_valid", 512'(blk_valid), 512'(1));
    @(posedge clk); #1;
    pulse_reset();
    ready_mode = 0;
    build_msg(5, 8'h7E);
    blocks_seen = 0;
    model_push();
    applyStimulus(1'b1);
    drain();
    checkOutput("mid_out_count", 512'(blocks_seen), 512'(1));
    checkOutput("mid_out_len", 512'(last_len_seen), 512'(64'h28));

    for (int r = 0; r < 25; r++) begin
      build_msg($urandom_range(1, 150), 300);
      ready_mode = 1;
      model_push();
      applyStimulus(1'b1);
      drain();
    end
    checkOutput("final_queue_empty", 512'(exp_q.size()), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
